// File: rtl/ram_mem_pkg.sv
// Shared widths, bus payload types and address range check for the dual-port RAM.
package ram_mem_pkg;

  localparam logic [63:0] BASE_DEFAULT = 64'h0000_0000_8000_0000;
  localparam int unsigned WORD_W       = 64;
  localparam int unsigned INST_W       = 32;
  localparam int unsigned STRB_W       = 8;

  typedef struct packed {
    logic              err;
    logic [INST_W-1:0] rdata;
  } inst_rsp_t;

  typedef struct packed {
    logic              err;
    logic [WORD_W-1:0] rdata;
  } data_rsp_t;

  // Subtract before comparing so a window ending at 2^64 is still handled.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] span);
    return (addr >= base) && ((addr - base) < span);
  endfunction

endpackage

// File: rtl/ram_mem_rsp_reg.sv
// Per-port single-entry response register; holds payload until the consumer takes it.
module ram_mem_rsp_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid_i,
  input  logic         rsp_ready_i,
  input  logic [W-1:0] payload_i,
  output logic         req_ready_c_o,
  output logic         accept_c_o,
  output logic         rsp_valid_o,
  output logic [W-1:0] payload_o
);

  logic         rsp_valid_q, rsp_valid_d;
  logic [W-1:0] payload_q, payload_d;

  assign req_ready_c_o = !rsp_valid_q || rsp_ready_i;
  assign accept_c_o    = req_valid_i && req_ready_c_o;

  always_comb begin
    rsp_valid_d = rsp_valid_q && !rsp_ready_i;
    payload_d   = payload_q;
    if (accept_c_o) begin
      rsp_valid_d = 1'b1;
      payload_d   = payload_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      payload_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      payload_q   <= payload_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign payload_o   = payload_q;

endmodule

// File: rtl/ram_mem_axi_lite.sv
// Dual-port (fetch + load/store) word RAM with registered responses.
// Define RAM_MEM_FWD_EN to forward same-cycle write data to a colliding fetch.
module ram_mem_axi_lite
  import ram_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter logic [63:0] BASE  = BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_req_valid,
  output logic              inst_req_ready,
  input  logic [63:0]       inst_addr,
  output logic              inst_rsp_valid,
  input  logic              inst_rsp_ready,
  output logic [INST_W-1:0] inst_rdata,
  output logic              inst_err,
  input  logic              data_req_valid,
  output logic              data_req_ready,
  input  logic              data_we,
  input  logic [63:0]       data_addr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [WORD_W-1:0] data_wdata,
  output logic              data_rsp_valid,
  input  logic              data_rsp_ready,
  output logic [WORD_W-1:0] data_rdata,
  output logic              data_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [63:0] SPAN  = 64'(DEPTH) << 3;

  logic [WORD_W-1:0] mem_q [DEPTH];

  logic              i_ok, d_ok, i_acc, d_acc, d_wr;
  logic [IDX_W-1:0]  i_idx, d_idx;
  logic [WORD_W-1:0] i_word;
  inst_rsp_t         i_rsp, i_rsp_q;
  data_rsp_t         d_rsp, d_rsp_q;

  assign i_ok  = addr_in_range(inst_addr, BASE, SPAN);
  assign d_ok  = addr_in_range(data_addr, BASE, SPAN);
  assign i_idx = IDX_W'((inst_addr - BASE) >> 3);
  assign d_idx = IDX_W'((data_addr - BASE) >> 3);
  assign d_wr  = d_acc && data_we && d_ok;

  // Fetch reads the pre-edge array; optionally overlay the colliding write.
  always_comb begin
    i_word = mem_q[i_idx];
`ifdef RAM_MEM_FWD_EN
    if (d_wr && (d_idx == i_idx)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (data_wstrb[b]) i_word[8*b +: 8] = data_wdata[8*b +: 8];
      end
    end
`endif
    i_rsp = '0;
    if (i_ok) i_rsp.rdata = inst_addr[2] ? i_word[63:32] : i_word[31:0];
    else      i_rsp.err   = 1'b1;
  end

  always_comb begin
    d_rsp = '0;
    if (!d_ok)         d_rsp.err   = 1'b1;
    else if (!data_we) d_rsp.rdata = mem_q[d_idx];
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (d_wr) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (data_wstrb[b]) mem_q[d_idx][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
  end

  ram_mem_rsp_reg #(.W($bits(inst_rsp_t))) u_inst_rsp (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (inst_req_valid),
    .rsp_ready_i   (inst_rsp_ready),
    .payload_i     (i_rsp),
    .req_ready_c_o (inst_req_ready),
    .accept_c_o    (i_acc),
    .rsp_valid_o   (inst_rsp_valid),
    .payload_o     (i_rsp_q)
  );

  ram_mem_rsp_reg #(.W($bits(data_rsp_t))) u_data_rsp (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (data_req_valid),
    .rsp_ready_i   (data_rsp_ready),
    .payload_i     (d_rsp),
    .req_ready_c_o (data_req_ready),
    .accept_c_o    (d_acc),
    .rsp_valid_o   (data_rsp_valid),
    .payload_o     (d_rsp_q)
  );

  assign inst_rdata = i_rsp_q.rdata;
  assign inst_err   = i_rsp_q.err;
  assign data_rdata = d_rsp_q.rdata;
  assign data_err   = d_rsp_q.err;

  logic unused_i_acc;
  assign unused_i_acc = i_acc;

endmodule
